// File: rtl/alu_system.sv
// ---------------------------------------------------------------------------
// alu_system
// Single-clock 8-bit datapath: general register file (R1-R4), address
// register file (AR, SP, PC), 16-bit instruction register, 256x8 memory,
// 16-function ALU with registered {Z,C,N,O} flags, and the A/B/C muxes.
// Every control input is supplied externally each cycle.
//
// Ports
//   Clock, Reset (async, active-low)
//   RF_OutASel/OutBSel/FunSel/RegSel    general register file control
//   ALU_FunSel                          ALU operation
//   ARF_OutCSel/OutDSel/FunSel/RegSel   address register file control
//   IR_LH, IR_Enable, IR_Funsel         instruction register control
//   Mem_WR, Mem_CS                      memory write / chip select (low)
//   MuxASel, MuxBSel, MuxCSel           mux selects
//   AOut, BOut, ALUOut, ALUOutFlag, ARF_COut, Address, MemoryOut,
//   IROut, MuxAOut, MuxBOut, MuxCOut    observed internal buses
//
// Memory: every location starts at 8'h00.
// ---------------------------------------------------------------------------

// Generic counter/load register shared by RF and ARF.
// funsel: 00 dec, 01 inc, 10 load, 11 clear (wrapping arithmetic).
module alu_system_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [1:0]   i_funsel,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            case (i_funsel)
                2'b00:   r_q <= r_q - 1'b1;
                2'b01:   r_q <= r_q + 1'b1;
                2'b10:   r_q <= i_d;
                default: r_q <= '0;
            endcase
        end
    end

    assign o_q = r_q;
endmodule

module alu_system (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  RF_OutASel,
    input  logic [1:0]  RF_OutBSel,
    input  logic [1:0]  RF_FunSel,
    input  logic [3:0]  RF_RegSel,
    input  logic [3:0]  ALU_FunSel,
    input  logic [1:0]  ARF_OutCSel,
    input  logic [1:0]  ARF_OutDSel,
    input  logic [1:0]  ARF_FunSel,
    input  logic [2:0]  ARF_RegSel,
    input  logic        IR_LH,
    input  logic        IR_Enable,
    input  logic [1:0]  IR_Funsel,
    input  logic        Mem_WR,
    input  logic        Mem_CS,
    input  logic [1:0]  MuxASel,
    input  logic [1:0]  MuxBSel,
    input  logic [1:0]  MuxCSel,
    output logic [7:0]  AOut,
    output logic [7:0]  BOut,
    output logic [7:0]  ALUOut,
    output logic [3:0]  ALUOutFlag,
    output logic [7:0]  ARF_COut,
    output logic [7:0]  Address,
    output logic [7:0]  MemoryOut,
    output logic [15:0] IROut,
    output logic [7:0]  MuxAOut,
    output logic [7:0]  MuxBOut,
    output logic [7:0]  MuxCOut
);
    localparam int NUM_RF  = 4;
    localparam int NUM_ARF = 3;

    // ---------------- general register file ----------------
    // Index 0..3 = R1..R4; RegSel bit 3 enables R1, so it is reversed.
    logic [NUM_RF-1:0][7:0] w_rf;

    genvar g;
    generate
        for (g = 0; g < NUM_RF; g++) begin : g_rf
            alu_system_reg #(.W(8)) u_reg (
                .i_clk    (Clock),
                .i_rst_n  (Reset),
                .i_en     (RF_RegSel[NUM_RF-1-g]),
                .i_funsel (RF_FunSel),
                .i_d      (MuxAOut),
                .o_q      (w_rf[g])
            );
        end
    endgenerate

    assign AOut = w_rf[RF_OutASel];
    assign BOut = w_rf[RF_OutBSel];

    // ---------------- address register file ----------------
    // Index 0 = AR, 1 = SP, 2 = PC, matching the read-select encoding.
    logic [NUM_ARF-1:0][7:0] w_arf;
    logic [NUM_ARF-1:0]      w_arf_en;

    assign w_arf_en = {ARF_RegSel[2], ARF_RegSel[0], ARF_RegSel[1]};

    generate
        for (g = 0; g < NUM_ARF; g++) begin : g_arf
            alu_system_reg #(.W(8)) u_reg (
                .i_clk    (Clock),
                .i_rst_n  (Reset),
                .i_en     (w_arf_en[g]),
                .i_funsel (ARF_FunSel),
                .i_d      (MuxBOut),
                .o_q      (w_arf[g])
            );
        end
    endgenerate

    always_comb begin
        case (ARF_OutCSel)
            2'b00:   ARF_COut = w_arf[0];
            2'b01:   ARF_COut = w_arf[1];
            default: ARF_COut = w_arf[2];
        endcase
    end

    always_comb begin
        case (ARF_OutDSel)
            2'b00:   Address = w_arf[0];
            2'b01:   Address = w_arf[1];
            default: Address = w_arf[2];
        endcase
    end

    // ---------------- instruction register ----------------
    // Load writes one byte from memory; inc/dec/clear act on all 16 bits.
    logic [15:0] r_ir;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ir <= '0;
        end else if (IR_Enable) begin
            case (IR_Funsel)
                2'b00:   r_ir <= r_ir - 16'd1;
                2'b01:   r_ir <= r_ir + 16'd1;
                2'b10: begin
                    if (IR_LH) r_ir[15:8] <= MemoryOut;
                    else       r_ir[7:0]  <= MemoryOut;
                end
                default: r_ir <= '0;
            endcase
        end
    end

    assign IROut = r_ir;

    // ---------------- memory ----------------
    // Contents are not touched by Reset.
    logic [7:0] r_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) r_mem[i] = 8'h00;
    end

    always_ff @(posedge Clock) begin
        if (!Mem_CS && Mem_WR) r_mem[Address] <= ALUOut;
    end

    assign MemoryOut = (!Mem_CS && !Mem_WR) ? r_mem[Address] : 8'h00;

    // ---------------- muxes ----------------
    always_comb begin
        case (MuxASel)
            2'b00:   MuxAOut = ALUOut;
            2'b01:   MuxAOut = MemoryOut;
            2'b10:   MuxAOut = r_ir[7:0];
            default: MuxAOut = ARF_COut;
        endcase
    end

    always_comb begin
        case (MuxBSel)
            2'b00:   MuxBOut = ALUOut;
            2'b01:   MuxBOut = MemoryOut;
            2'b10:   MuxBOut = r_ir[7:0];
            default: MuxBOut = ARF_COut;
        endcase
    end

    // Only bit 0 of MuxCSel is meaningful.
    assign MuxCOut = MuxCSel[0] ? ARF_COut : AOut;

    // ---------------- ALU ----------------
    // r_flag = {Z, C, N, O}. C and O hold unless the operation defines them.
    logic [3:0] r_flag;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic       w_cin;
    logic [8:0] w_sum;
    logic [7:0] w_res;
    logic       w_c_nx;
    logic       w_o_nx;

    assign w_a   = MuxCOut;
    assign w_b   = BOut;
    assign w_cin = r_flag[2];

    always_comb begin
        w_sum  = '0;
        w_res  = w_a;
        w_c_nx = r_flag[2];
        w_o_nx = r_flag[0];
        case (ALU_FunSel)
            4'h0: w_res = w_a;
            4'h1: w_res = w_b;
            4'h2: w_res = ~w_a;
            4'h3: w_res = ~w_b;
            4'h4: begin
                w_sum  = {1'b0, w_a} + {1'b0, w_b};
                w_res  = w_sum[7:0];
                w_c_nx = w_sum[8];
                w_o_nx = (w_a[7] == w_b[7]) && (w_res[7] != w_a[7]);
            end
            4'h5: begin
                w_sum  = {1'b0, w_a} + {1'b0, w_b} + {8'h00, w_cin};
                w_res  = w_sum[7:0];
                w_c_nx = w_sum[8];
                w_o_nx = (w_a[7] == w_b[7]) && (w_res[7] != w_a[7]);
            end
            4'h6: begin
                // Subtract as A + ~B + 1; overflow when operand signs differ
                // and the result sign departs from A.
                w_sum  = {1'b0, w_a} + {1'b0, ~w_b} + 9'd1;
                w_res  = w_sum[7:0];
                w_c_nx = w_sum[8];
                w_o_nx = (w_a[7] != w_b[7]) && (w_res[7] != w_a[7]);
            end
            4'h7: w_res = w_a & w_b;
            4'h8: w_res = w_a | w_b;
            4'h9: w_res = w_a ^ w_b;
            4'hA: begin
                w_res  = {w_a[6:0], 1'b0};
                w_c_nx = w_a[7];
            end
            4'hB: begin
                w_res  = {1'b0, w_a[7:1]};
                w_c_nx = w_a[0];
            end
            4'hC: begin
                w_res  = {w_a[6:0], 1'b0};
                w_c_nx = w_a[7];
                w_o_nx = w_a[7] ^ w_a[6];
            end
            4'hD: w_res = {w_a[7], w_a[7:1]};   // carry deliberately held
            4'hE: begin
                w_res  = {w_a[6:0], w_cin};
                w_c_nx = w_a[7];
            end
            default: begin
                w_res  = {w_cin, w_a[7:1]};
                w_c_nx = w_a[0];
            end
        endcase
    end

    assign ALUOut = w_res;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_flag <= '0;
        end else begin
            r_flag <= {(w_res == 8'h00), w_c_nx, w_res[7], w_o_nx};
        end
    end

    assign ALUOutFlag = r_flag;
endmodule

// File: tb/tb_alu_system.sv
module tb_alu_system;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel, MuxCSel;
    logic [7:0]  AOut, BOut, ALUOut, ARF_COut, Address, MemoryOut;
    logic [7:0]  MuxAOut, MuxBOut, MuxCOut;
    logic [3:0]  ALUOutFlag;
    logic [15:0] IROut;

    alu_system dut (
        .Clock(Clock), .Reset(Reset),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
        .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
        .ALU_FunSel(ALU_FunSel),
        .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .AOut(AOut), .BOut(BOut), .ALUOut(ALUOut), .ALUOutFlag(ALUOutFlag),
        .ARF_COut(ARF_COut), .Address(Address), .MemoryOut(MemoryOut),
        .IROut(IROut), .MuxAOut(MuxAOut), .MuxBOut(MuxBOut), .MuxCOut(MuxCOut)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_r[4];                       // R1..R4
    int m_ar, m_sp, m_pc, m_ir;
    int m_z, m_c, m_n, m_o;
    int m_mem[256];
    int e_a, e_b, e_cout, e_addr, e_mem, e_mc, e_ma, e_mb, e_alu, e_cn, e_on;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_ar = 0; m_sp = 0; m_pc = 0; m_ir = 0;
        m_z = 0; m_c = 0; m_n = 0; m_o = 0;
    endtask

    function automatic int arf_pick(input int s);
        if (s == 0) return m_ar;
        if (s == 1) return m_sp;
        return m_pc;
    endfunction

    function automatic int mux_pick(input int s);
        if (s == 0) return e_alu;
        if (s == 1) return e_mem;
        if (s == 2) return m_ir % 256;
        return e_cout;
    endfunction

    function automatic int reg_op(input int fs, input int v, input int d, input int md);
        if (fs == 0) return (v + md - 1) % md;
        if (fs == 1) return (v + 1) % md;
        if (fs == 2) return d;
        return 0;
    endfunction

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic alu_ref(input int op, input int a, input int b);
        int r, s;
        r = 0; s = 0;
        e_cn = m_c; e_on = m_o;
        case (op)
            0:  r = a;
            1:  r = b;
            2:  r = 255 - a;
            3:  r = 255 - b;
            4:  begin r = a + b;        s = sgn(a) + sgn(b);
                      e_cn = (r > 255) ? 1 : 0; e_on = (s > 127 || s < -128) ? 1 : 0; end
            5:  begin r = a + b + m_c;  s = sgn(a) + sgn(b) + m_c;
                      e_cn = (r > 255) ? 1 : 0; e_on = (s > 127 || s < -128) ? 1 : 0; end
            6:  begin r = a + (255 - b) + 1; s = sgn(a) - sgn(b);
                      e_cn = (r > 255) ? 1 : 0; e_on = (s > 127 || s < -128) ? 1 : 0; end
            7:  r = a & b;
            8:  r = a | b;
            9:  r = a ^ b;
            10: begin r = a * 2; e_cn = a / 128; end
            11: begin r = a / 2; e_cn = a % 2; end
            12: begin r = a * 2; e_cn = a / 128; e_on = ((a / 128) != ((a / 64) % 2)) ? 1 : 0; end
            13: r = a / 2 + (a & 128);
            14: begin r = a * 2 + m_c; e_cn = a / 128; end
            default: begin r = a / 2 + m_c * 128; e_cn = a % 2; end
        endcase
        e_alu = r % 256;
    endtask

    task automatic model_comb();
        e_a    = m_r[RF_OutASel];
        e_b    = m_r[RF_OutBSel];
        e_cout = arf_pick(int'(ARF_OutCSel));
        e_addr = arf_pick(int'(ARF_OutDSel));
        e_mem  = (!Mem_CS && !Mem_WR) ? m_mem[e_addr] : 0;
        e_mc   = MuxCSel[0] ? e_cout : e_a;
        alu_ref(int'(ALU_FunSel), e_mc, e_b);
        e_ma   = mux_pick(int'(MuxASel));
        e_mb   = mux_pick(int'(MuxBSel));
    endtask

    // Applies one rising edge to the model using values computed before it.
    task automatic model_edge();
        for (int i = 0; i < 4; i++)
            if (RF_RegSel[3-i]) m_r[i] = reg_op(int'(RF_FunSel), m_r[i], e_ma, 256);
        if (ARF_RegSel[1]) m_ar = reg_op(int'(ARF_FunSel), m_ar, e_mb, 256);
        if (ARF_RegSel[0]) m_sp = reg_op(int'(ARF_FunSel), m_sp, e_mb, 256);
        if (ARF_RegSel[2]) m_pc = reg_op(int'(ARF_FunSel), m_pc, e_mb, 256);
        if (IR_Enable) begin
            if (IR_Funsel == 2'b10)
                m_ir = IR_LH ? (m_ir % 256) + e_mem * 256 : (m_ir - m_ir % 256) + e_mem;
            else
                m_ir = reg_op(int'(IR_Funsel), m_ir, 0, 65536);
        end
        if (!Mem_CS && Mem_WR) m_mem[e_addr] = e_alu;
        m_z = (e_alu == 0) ? 1 : 0;
        m_n = (e_alu >= 128) ? 1 : 0;
        m_c = e_cn;
        m_o = e_on;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".aout"},  16'(AOut),      16'(e_a));
        chk({tag, ".bout"},  16'(BOut),      16'(e_b));
        chk({tag, ".cout"},  16'(ARF_COut),  16'(e_cout));
        chk({tag, ".addr"},  16'(Address),   16'(e_addr));
        chk({tag, ".mem"},   16'(MemoryOut), 16'(e_mem));
        chk({tag, ".muxc"},  16'(MuxCOut),   16'(e_mc));
        chk({tag, ".alu"},   16'(ALUOut),    16'(e_alu));
        chk({tag, ".muxa"},  16'(MuxAOut),   16'(e_ma));
        chk({tag, ".muxb"},  16'(MuxBOut),   16'(e_mb));
        chk({tag, ".ir"},    IROut,          16'(m_ir));
        chk({tag, ".flags"}, 16'(ALUOutFlag), 16'(m_z * 8 + m_c * 4 + m_n * 2 + m_o));
    endtask

    // Check combinational outputs, clock once, advance the model.
    task automatic step(input string tag);
        #1;
        model_comb();
        compare_all(tag);
        @(posedge Clock);
        #1;
        model_edge();
    endtask

    task automatic idle();
        RF_OutASel = 0; RF_OutBSel = 0; RF_FunSel = 0; RF_RegSel = 0;
        ALU_FunSel = 0;
        ARF_OutCSel = 0; ARF_OutDSel = 0; ARF_FunSel = 0; ARF_RegSel = 0;
        IR_LH = 0; IR_Enable = 0; IR_Funsel = 0;
        Mem_WR = 0; Mem_CS = 1;
        MuxASel = 0; MuxBSel = 0; MuxCSel = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
        idle();
        Reset = 0;
        #2;
        model_reset();
        model_comb();
        compare_all("rst");
        @(negedge Clock);
        Reset = 1;

        // PC increments three times, SP wraps below zero
        ARF_FunSel = 2'b01; ARF_RegSel = 3'b100;
        repeat (3) step("pcinc");
        ARF_RegSel = 0; ARF_OutDSel = 2'b10;
        #1 chk("pc_addr", 16'(Address), 16'h0003);
        ARF_FunSel = 2'b00; ARF_RegSel = 3'b001;
        step("spdec");
        ARF_RegSel = 0; ARF_OutCSel = 2'b01;
        #1 chk("sp_wrap", 16'(ARF_COut), 16'h00FF);

        // R1 = 2, R2 = 0xFF, then add
        RF_FunSel = 2'b01; RF_RegSel = 4'b1000;
        repeat (2) step("r1inc");
        RF_FunSel = 2'b00; RF_RegSel = 4'b0100;
        step("r2dec");
        RF_RegSel = 0; RF_OutASel = 2'b00; RF_OutBSel = 2'b01;
        MuxCSel = 2'b00; ALU_FunSel = 4'h4;
        #1 chk("add_res", 16'(ALUOut), 16'h0001);
        step("add");
        chk("add_flags", 16'(ALUOutFlag), 16'h0004);

        // memory write at PC=3, read back, chip-select off
        Mem_CS = 0; Mem_WR = 1;
        step("memwr");
        Mem_WR = 0;
        #1 chk("mem_rd", 16'(MemoryOut), 16'h0001);
        Mem_CS = 1;
        #1 chk("mem_cs", 16'(MemoryOut), 16'h0000);
        Mem_CS = 0;

        // IR loads low then high byte
        IR_Enable = 1; IR_Funsel = 2'b10; IR_LH = 0;
        step("irlo");
        IR_LH = 1;
        step("irhi");
        IR_Enable = 0; Mem_CS = 1;
        chk("ir_load", IROut, 16'h0101);

        // circular right shift with stored carry 1
        ALU_FunSel = 4'hF;
        #1 chk("csr_res", 16'(ALUOut), 16'h0081);
        step("csr");
        chk("csr_c", 16'(ALUOutFlag[2]), 16'h0000);
        chk("csr_n", 16'(ALUOutFlag[1]), 16'h0001);

        // R1 up to 5, then async reset between edges
        ALU_FunSel = 4'h0;
        RF_FunSel = 2'b01; RF_RegSel = 4'b1000;
        repeat (3) step("r1to5");
        RF_RegSel = 0;
        #1 chk("r1_5", 16'(AOut), 16'h0005);
        #2 Reset = 0;
        #1;
        model_reset();
        model_comb();
        compare_all("arst");
        chk("arst_flags", 16'(ALUOutFlag), 16'h0000);
        #2 Reset = 1;

        // randomized traffic against the model
        repeat (500) begin
            RF_OutASel  = 2'($urandom_range(0, 3));
            RF_OutBSel  = 2'($urandom_range(0, 3));
            RF_FunSel   = 2'($urandom_range(0, 3));
            RF_RegSel   = 4'($urandom_range(0, 15));
            ALU_FunSel  = 4'($urandom_range(0, 15));
            ARF_OutCSel = 2'($urandom_range(0, 3));
            ARF_OutDSel = 2'($urandom_range(0, 3));
            ARF_FunSel  = 2'($urandom_range(0, 3));
            ARF_RegSel  = 3'($urandom_range(0, 7));
            IR_LH       = 1'($urandom_range(0, 1));
            IR_Enable   = 1'($urandom_range(0, 1));
            IR_Funsel   = 2'($urandom_range(0, 3));
            Mem_WR      = 1'($urandom_range(0, 1));
            Mem_CS      = 1'($urandom_range(0, 1));
            MuxASel     = 2'($urandom_range(0, 3));
            MuxBSel     = 2'($urandom_range(0, 3));
            MuxCSel     = 2'($urandom_range(0, 3));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
